// File: rtl/aemb2_pkg.sv
// Shared encodings for the AEMB2 datapath: write-back classes, load sizes
// and a helper that says whether a write-back class targets the register file.
package aemb2_pkg;

  localparam int REG_AW = 5;
  localparam int REG_DW = 32;

  // Write-back class carried alongside each instruction from EX onward.
  typedef enum logic [1:0] {
    OPD_ALU   = 2'd0,
    OPD_LOAD  = 2'd1,
    OPD_NONE  = 2'd2,
    OPD_NONE3 = 2'd3
  } opd_e;

  // Load access size.
  typedef enum logic [1:0] {
    SIZ_BYTE = 2'd0,
    SIZ_HALF = 2'd1,
    SIZ_WORD = 2'd2,
    SIZ_RSVD = 2'd3
  } siz_e;

  // True for the classes that produce a register write.
  function automatic logic opd_writes(input logic [1:0] opd);
    return (opd == OPD_ALU) || (opd == OPD_LOAD);
  endfunction

endpackage

// File: rtl/aemb2_ldfmt.sv
// Big-endian load lane steering with zero extension. Misaligned low address
// bits are simply ignored for half and word accesses.
module aemb2_ldfmt
  import aemb2_pkg::*;
(
  input  logic [31:0] dat_i,
  input  logic [1:0]  adr_i,
  input  logic [1:0]  siz_i,
  output logic [31:0] dat_o
);

  // Select the addressed byte/half lane; lane 0 is the most significant.
  always_comb begin
    dat_o = dat_i;
    case (siz_i)
      SIZ_BYTE: begin
        case (adr_i)
          2'd0:    dat_o = {24'h0, dat_i[31:24]};
          2'd1:    dat_o = {24'h0, dat_i[23:16]};
          2'd2:    dat_o = {24'h0, dat_i[15:8]};
          default: dat_o = {24'h0, dat_i[7:0]};
        endcase
      end
      SIZ_HALF: begin
        if (adr_i[1]) dat_o = {16'h0, dat_i[15:0]};
        else          dat_o = {16'h0, dat_i[31:16]};
      end
      default: dat_o = dat_i;
    endcase
  end

endmodule

// File: rtl/aemb2_regf.sv
// Two-thread register file for the AEMB2 pipeline. Reads are addressed from
// IF and registered into OF; writes come from the MA stage, which holds the
// EX instruction one cycle later. Load data is kept in a hold register so an
// acknowledge that arrives during a stall is not lost.
module aemb2_regf
  import aemb2_pkg::*;
#(
  parameter int TXE = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ena_i,
  input  logic        pha_i,
  input  logic        rMSR_TXE,
  input  logic [4:0]  rRD_IF,
  input  logic [4:0]  rRA_IF,
  input  logic [4:0]  rRB_IF,
  input  logic [4:0]  rRD_EX,
  input  logic [1:0]  rOPD_EX,
  input  logic [31:0] rRES_EX,
  input  logic [1:0]  rSIZ_EX,
  input  logic [31:0] dwb_dat_i,
  input  logic        dwb_ack_i,
  output logic [31:0] rREGD_OF,
  output logic [31:0] rREGA_OF,
  output logic [31:0] rREGB_OF
);

  // MA stage state.
  logic [4:0]  rd_ma_q,   rd_ma_d;
  logic [1:0]  opd_ma_q,  opd_ma_d;
  logic [31:0] res_ma_q,  res_ma_d;
  logic [1:0]  siz_ma_q,  siz_ma_d;
  logic        bank_ma_q, bank_ma_d;

  // Load data hold and registered operands.
  logic [31:0] hold_q, hold_d;
  logic [31:0] regd_q, regd_d;
  logic [31:0] rega_q, rega_d;
  logic [31:0] regb_q, regb_d;

  // Both banks live in one array indexed by {bank, address}.
  logic [31:0] rf_q [64];

  logic        thr_en;
  logic        rd_bank;
  logic        ex_bank;
  logic        wr_en;
  logic [31:0] wr_dat;
  logic [31:0] ld_dat;

  // Thread banking collapses to bank 0 when the second bank is absent or off.
  // The IF thread reads; the opposite-phase thread is the one in EX.
  always_comb begin
    thr_en  = (TXE != 0) && rMSR_TXE;
    rd_bank = thr_en & ~pha_i;
    ex_bank = thr_en & pha_i;
  end

  aemb2_ldfmt u_ldfmt (
    .dat_i (hold_q),
    .adr_i (res_ma_q[1:0]),
    .siz_i (siz_ma_q),
    .dat_o (ld_dat)
  );

  // Write port: reset cancels the pending write, r0 is never written.
  always_comb begin
    wr_en  = ~rst_i & ena_i & opd_writes(opd_ma_q) & (rd_ma_q != 5'd0);
    wr_dat = (opd_ma_q == OPD_ALU) ? res_ma_q : ld_dat;
  end

  // One read port: r0 reads zero, a same-cycle write to the same slot wins.
  function automatic logic [31:0] rd_port(input logic [4:0] a, input logic hit,
                                          input logic [31:0] wd, input logic [31:0] mw);
    if (a == 5'd0) return 32'h0;
    if (hit)       return wd;
    return mw;
  endfunction

  // Next state for MA capture, hold register and operand registers.
  always_comb begin
    rd_ma_d   = rd_ma_q;
    opd_ma_d  = opd_ma_q;
    res_ma_d  = res_ma_q;
    siz_ma_d  = siz_ma_q;
    bank_ma_d = bank_ma_q;
    hold_d    = hold_q;
    regd_d    = regd_q;
    rega_d    = rega_q;
    regb_d    = regb_q;
    if (rst_i) begin
      rd_ma_d   = 5'd0;
      opd_ma_d  = OPD_NONE;
      res_ma_d  = 32'h0;
      siz_ma_d  = SIZ_WORD;
      bank_ma_d = 1'b0;
      hold_d    = 32'h0;
      regd_d    = 32'h0;
      rega_d    = 32'h0;
      regb_d    = 32'h0;
    end else begin
      if (dwb_ack_i) hold_d = dwb_dat_i;
      if (ena_i) begin
        rd_ma_d   = rRD_EX;
        opd_ma_d  = rOPD_EX;
        res_ma_d  = rRES_EX;
        siz_ma_d  = rSIZ_EX;
        bank_ma_d = ex_bank;
        regd_d = rd_port(rRD_IF, wr_en && (bank_ma_q == rd_bank) && (rd_ma_q == rRD_IF),
                         wr_dat, rf_q[{rd_bank, rRD_IF}]);
        rega_d = rd_port(rRA_IF, wr_en && (bank_ma_q == rd_bank) && (rd_ma_q == rRA_IF),
                         wr_dat, rf_q[{rd_bank, rRA_IF}]);
        regb_d = rd_port(rRB_IF, wr_en && (bank_ma_q == rd_bank) && (rd_ma_q == rRB_IF),
                         wr_dat, rf_q[{rd_bank, rRB_IF}]);
      end
    end
  end

  // Pipeline and operand registers.
  always_ff @(posedge clk_i) begin
    rd_ma_q   <= rd_ma_d;
    opd_ma_q  <= opd_ma_d;
    res_ma_q  <= res_ma_d;
    siz_ma_q  <= siz_ma_d;
    bank_ma_q <= bank_ma_d;
    hold_q    <= hold_d;
    regd_q    <= regd_d;
    rega_q    <= rega_d;
    regb_q    <= regb_d;
  end

  // Register array: no reset, contents survive rst_i.
  always_ff @(posedge clk_i) begin
    if (wr_en) rf_q[{bank_ma_q, rd_ma_q}] <= wr_dat;
  end

  assign rREGD_OF = regd_q;
  assign rREGA_OF = rega_q;
  assign rREGB_OF = regb_q;

endmodule

// File: doc/aemb2_regf.md
AEMB2_REGF -- requirements
Module: aemb2_regf

Interface
REQ-001 SHALL have parameter TXE, default 1, meaning the second hardware thread bank is implemented.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have port ena_i, input, 1, pipeline advance; low means hold all state.
REQ-005 SHALL have port pha_i, input, 1, thread phase: 1 = thread 0 in IF, 0 = thread 1 in IF.
REQ-006 SHALL have port rMSR_TXE, input, 1, thread-extension enable.
REQ-007 SHALL have ports rRD_IF, rRA_IF, rRB_IF, input, 5 each, read addresses for the instruction in IF.
REQ-008 SHALL have ports rRD_EX, input, 5, and rOPD_EX, input, 2, destination and write-back class of the instruction in EX.
REQ-009 SHALL have port rRES_EX, input, 32, ALU result or load address from EX.
REQ-010 SHALL have port rSIZ_EX, input, 2, load size: 00 byte, 01 half, 10 word.
REQ-011 SHALL have ports dwb_dat_i, input, 32, and dwb_ack_i, input, 1, data-bus read data and acknowledge.
REQ-012 SHALL have ports rREGD_OF, rREGA_OF, rREGB_OF, output, 32 each, registered operands for OF.

Function
REQ-013 SHALL hold two 32x32 banks; bank 0 = thread 0, bank 1 = thread 1; if TXE=0 or rMSR_TXE=0, all accesses use bank 0.
REQ-014 SHALL select the read bank as !pha_i? no: bank 0 when pha_i=1, bank 1 when pha_i=0.
REQ-015 SHALL, when ena_i=1, capture rRD_EX, rOPD_EX, rRES_EX, rSIZ_EX and the EX-stage bank (bank of the opposite phase) into an MA stage.
REQ-016 SHALL decode rOPD: 0 = write ALU result, 1 = write load data, 2 and 3 = no write.
REQ-017 SHALL latch dwb_dat_i into a hold register on any cycle dwb_ack_i=1, regardless of ena_i, so data survives a stall.
REQ-018 SHALL format load data big-endian from the hold register: byte lane by MA address[1:0] (00 = bits 31:24), half lane by address[1], word unchanged; zero-extend to 32 bits.
REQ-019 SHALL write the MA result into the MA bank at rRD_MA on the cycle ena_i=1 and rOPD_MA is 0 or 1 and rRD_MA != 0.
REQ-020 SHALL never write register 0; reads of address 0 SHALL return 32'h0.
REQ-021 SHALL update rREGD_OF, rREGA_OF, rREGB_OF only when ena_i=1, latency one cycle from address presentation.
REQ-022 SHALL bypass the same-cycle write data to an output when bank and address match the write (write-before-read).
REQ-023 SHALL hold all outputs and MA state unchanged while ena_i=0.
REQ-024 SHALL ignore misaligned size/address combinations by steering per REQ-018 on the ignored low bits (half ignores bit 0, word ignores bits 1:0).

Reset
REQ-025 SHALL on rst_i=1 clear rREGD_OF, rREGA_OF, rREGB_OF and the hold register to 32'h0.
REQ-026 SHALL on rst_i=1 force rOPD_MA to 2 (no write), discarding any pending write; rst_i overrides ena_i.
REQ-027 SHALL NOT reset register-array contents; only register 0 is guaranteed zero.

Structure
REQ-028 SHALL take rOPD encodings (ALU, LOAD, NONE) and size codes (BYTE, HALF, WORD) from the shared package aemb2_pkg.
REQ-029 SHALL place load lane steering and zero-extension in one combinational sub-module aemb2_ldfmt.

Verification
REQ-030 ALU write: rOPD_EX=0, rRD_EX=5, rRES_EX=32'hDEADBEEF, thread 0; later read rRA_IF=5 in thread 0 -> rREGA_OF=32'hDEADBEEF; thread 1 read r5 unchanged.
REQ-031 Byte load: rSIZ_EX=00, address low bits 2'b10, dwb_dat_i=32'h11223344 -> destination gets 32'h00000033; half at bit1=0 -> 32'h00001122.
REQ-032 Stall: ack arrives with ena_i=0 for 3 cycles, dwb_dat_i changes afterwards -> written value equals acked data; outputs unchanged during stall.
REQ-033 r0: ALU write to rRD=0 with 32'hFFFFFFFF -> reads of r0 return 32'h0.
REQ-034 Bypass: write r7=32'h12345678 while reading rRB_IF=7 same bank same cycle -> rREGB_OF=32'h12345678.
REQ-035 Reset mid-load: rst_i asserted with load pending in MA -> no write occurs, outputs 0, prior r-contents intact.
